// File: rtl/pb_gesture_decoder.sv
// Push-button gesture classifier: turns debounced press/release pulses into
// short, double-click, long-press and auto-repeat event pulses.
//
// state     | meaning
// IDLE      | button up, nothing pending
// PRESS1    | first press held, timing toward long press
// WAIT2     | released after short press, waiting for a second press
// DRAIN     | double click emitted, waiting for the second release
// LONG_HELD | long press emitted, auto-repeating until release
module pb_gesture_decoder #(
  parameter int LONG_CYCLES   = 25_000_000,
  parameter int DCLICK_GAP    = 12_500_000,
  parameter int REPEAT_CYCLES = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic pressed_pulse,
  input  logic released_pulse,
  input  logic clear,
  output logic short_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam int MAX_AB     = (LONG_CYCLES > DCLICK_GAP) ? LONG_CYCLES : DCLICK_GAP;
  localparam int MAX_CYCLES = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(DCLICK_GAP - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS1,
    S_WAIT2,
    S_DRAIN,
    S_LONG_HELD
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             short_d, double_d, long_d, repeat_d, held_d;
  logic             press_ok;

  // A release in the same cycle as a press always wins.
  assign press_ok = pressed_pulse & ~released_pulse;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      short_pulse  <= 1'b0;
      double_pulse <= 1'b0;
      long_pulse   <= 1'b0;
      repeat_pulse <= 1'b0;
      held         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      short_pulse  <= short_d;
      double_pulse <= double_d;
      long_pulse   <= long_d;
      repeat_pulse <= repeat_d;
      held         <= held_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    short_d  = 1'b0;
    double_d = 1'b0;
    long_d   = 1'b0;
    repeat_d = 1'b0;

    if (clear) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (press_ok) state_d = S_PRESS1;
        end
        S_PRESS1: begin
          if (released_pulse) begin
            state_d = S_WAIT2;
          end else if (cnt_q == LONG_LAST) begin
            state_d = S_LONG_HELD;
            long_d  = 1'b1;
          end
        end
        S_WAIT2: begin
          if (press_ok) begin
            state_d  = S_DRAIN;
            double_d = 1'b1;
          end else if (cnt_q == GAP_LAST) begin
            state_d = S_IDLE;
            short_d = 1'b1;
          end
        end
        S_DRAIN: begin
          // Unbounded wait, so the counter is parked rather than left to wrap.
          cnt_d = '0;
          if (released_pulse) state_d = S_IDLE;
        end
        S_LONG_HELD: begin
          if (released_pulse) begin
            state_d = S_IDLE;
          end else if (cnt_q == REPEAT_LAST) begin
            repeat_d = 1'b1;
            cnt_d    = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d != state_q) cnt_d = '0;
    held_d = (state_d == S_PRESS1) || (state_d == S_DRAIN) || (state_d == S_LONG_HELD);
  end

endmodule

// File: tb/tb_pb_gesture_decoder.sv
// Bench for pb_gesture_decoder: table scenarios with fixed event times, async
// reset check, then random press/release/clear traffic against a timestamp model.
module tb_pb_gesture_decoder;

  localparam int LONG_CYCLES   = 8;
  localparam int DCLICK_GAP    = 6;
  localparam int REPEAT_CYCLES = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pressed_pulse = 1'b0;
  logic released_pulse = 1'b0;
  logic clear = 1'b0;
  logic short_pulse, double_pulse, long_pulse, repeat_pulse, held;

  always #5 clk = ~clk;

  pb_gesture_decoder #(
    .LONG_CYCLES  (LONG_CYCLES),
    .DCLICK_GAP   (DCLICK_GAP),
    .REPEAT_CYCLES(REPEAT_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .pressed_pulse (pressed_pulse),
    .released_pulse(released_pulse),
    .clear         (clear),
    .short_pulse   (short_pulse),
    .double_pulse  (double_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: mode plus the absolute cycle the mode was entered.
  localparam int M_IDLE = 0, M_DOWN = 1, M_GAP = 2, M_DRAIN = 3, M_LONG = 4;
  int   cyc = 0;
  int   m_mode = M_IDLE;
  int   m_t0 = 0;
  logic [4:0] m_exp = '0;   // {short, double, long, repeat, held}

  task automatic model_reset();
    m_mode = M_IDLE;
    m_t0   = cyc;
    m_exp  = '0;
  endtask

  task automatic model_step(input bit p, input bit r, input bit c);
    int el;
    int nxt;
    bit es, ed, el_p, er;
    el = cyc - m_t0;
    nxt = m_mode;
    es = 0; ed = 0; el_p = 0; er = 0;
    if (c) nxt = M_IDLE;
    else begin
      case (m_mode)
        M_IDLE:  if (p && !r) nxt = M_DOWN;
        M_DOWN:  if (r) nxt = M_GAP;
                 else if (el >= LONG_CYCLES - 1) begin nxt = M_LONG; el_p = 1; end
        M_GAP:   if (p && !r) begin nxt = M_DRAIN; ed = 1; end
                 else if (el >= DCLICK_GAP - 1) begin nxt = M_IDLE; es = 1; end
        M_DRAIN: if (r) nxt = M_IDLE;
        M_LONG:  if (r) nxt = M_IDLE;
                 else if (el % REPEAT_CYCLES == REPEAT_CYCLES - 1) er = 1;
        default: nxt = M_IDLE;
      endcase
    end
    if (nxt != m_mode) m_t0 = cyc + 1;
    m_mode = nxt;
    m_exp = {es, ed, el_p, er, (nxt == M_DOWN || nxt == M_DRAIN || nxt == M_LONG)};
  endtask

  function automatic logic [4:0] dut_out();
    return {short_pulse, double_pulse, long_pulse, repeat_pulse, held};
  endfunction

  task automatic check5(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got {s,d,l,r,h}=%b expected %b", name, cyc, act, exp);
    end
  endtask

  // Drive one cycle of inputs, step the model, then sample just after the edge.
  task automatic cycle(input bit p, input bit r, input bit c);
    logic [3:0] pulses;
    pressed_pulse  = p;
    released_pulse = r;
    clear          = c;
    model_step(p, r, c);
    @(posedge clk);
    #1;
    cyc++;
    check5("model", dut_out(), m_exp);
    pulses = {short_pulse, double_pulse, long_pulse, repeat_pulse};
    n_cmp++;
    if ($countones(pulses) > 1) begin
      n_err++;
      $display("FAIL onehot cyc=%0d got pulses=%b expected at most one set", cyc, pulses);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b0;
    pressed_pulse = 0; released_pulse = 0; clear = 0;
    repeat (2) @(posedge clk);
    #1;
    check5("reset", dut_out(), 5'b0);
    rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    string name;
    int p0, r0, p1, r1, clr, len;
    int e_short, e_double, e_long, rep0, rep_n;
  } vec_t;

  function automatic bit rep_hit(input vec_t v, input int t);
    if (v.rep_n == 0 || t < v.rep0) return 0;
    return ((t - v.rep0) % REPEAT_CYCLES == 0) && ((t - v.rep0) / REPEAT_CYCLES < v.rep_n);
  endfunction

  task automatic run_vec(input vec_t v);
    bit p, r, k;
    logic [3:0] exp;
    reset_dut();
    for (int c = 0; c < v.len; c++) begin
      p = (c == v.p0) || (c == v.p1);
      r = (c == v.r0) || (c == v.r1);
      k = (c == v.clr);
      cycle(p, r, k);
      exp = {(c + 1) == v.e_short, (c + 1) == v.e_double, (c + 1) == v.e_long, rep_hit(v, c + 1)};
      n_cmp++;
      if ({short_pulse, double_pulse, long_pulse, repeat_pulse} !== exp) begin
        n_err++;
        $display("FAIL %s t=%0d got {s,d,l,r}=%b expected %b", v.name, c + 1,
                 {short_pulse, double_pulse, long_pulse, repeat_pulse}, exp);
      end
      if (v.name == "short" && c + 1 <= 5) begin
        check5("short_held", {4'b0, held}, {4'b0, (c + 1 >= 1 && c + 1 <= 3)});
      end
    end
  endtask

  vec_t vecs[8];

  initial begin
    //           name       p0 r0  p1  r1 clr len sh  db  lg rep0 n
    vecs[0] = '{"short",     0, 3, -1, -1, -1, 14, 10, -1, -1, -1, 0};
    vecs[1] = '{"double",    0, 2,  5,  7, -1, 14, -1,  6, -1, -1, 0};
    vecs[2] = '{"long_rep",  0, 22, -1, -1, -1, 28, -1, -1,  9, 13, 3};
    vecs[3] = '{"rel_at_lim",0, 8, -1, -1, -1, 18, 15, -1, -1, -1, 0};
    vecs[4] = '{"press_gap", 0, 2,  8, 10, -1, 16, -1,  9, -1, -1, 0};
    vecs[5] = '{"clear",     0, 7, -1, -1,  5, 20, -1, -1, -1, -1, 0};
    vecs[6] = '{"same_cyc",  0, 0, -1, -1, -1, 10, -1, -1, -1, -1, 0};
    vecs[7] = '{"rel_vs_rep",0, 16, -1, -1, -1, 24, -1, -1,  9, 13, 1};

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Asynchronous reset while auto-repeating: outputs drop without a clock edge.
    reset_dut();
    cycle(1, 0, 0);
    for (int i = 0; i < 11; i++) cycle(0, 0, 0);
    check5("pre_async_held", {4'b0, held}, 5'b00001);
    #2;
    rst = 1'b0;
    #1;
    check5("async_reset", dut_out(), 5'b0);
    reset_dut();

    // Random traffic in phases with different press/release/clear densities.
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 600; i++) begin
        bit p, r, k;
        p = ($urandom_range(0, 99) < 10 + 5 * ph);
        r = ($urandom_range(0, 99) < 4 + 6 * ph);
        k = ($urandom_range(0, 199) == 0);
        cycle(p, r, k);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
